// File: rtl/pht_access_scheduler.sv
// Port sequencer for the single-port PHT SRAM: init walk, read/update arbitration, update FIFO, RMW.
// Optional statistics counters are built when PHT_STATS_EN is defined.
module pht_access_scheduler #(
  parameter int unsigned INDEX_W    = 9,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INIT_VAL   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rd_valid,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_ready,
  output logic               o_rd_valid,
  output logic               o_rd_taken,
  output logic [CNT_W-1:0]   o_rd_counter,
  input  logic               i_up_valid,
  input  logic [INDEX_W-1:0] i_up_index,
  input  logic               i_up_taken,
  output logic               o_up_ready,
  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic [INDEX_W-1:0] o_mem_addr,
  output logic [CNT_W-1:0]   o_mem_wdata,
  input  logic [CNT_W-1:0]   i_mem_rdata,
  output logic               o_init_busy,
  output logic [31:0]        o_stat_stall_cnt,
  output logic [31:0]        o_stat_upd_cnt
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTF_W    = PTR_W + 1;
  localparam int unsigned LAST_ADDR = (1 << INDEX_W) - 1;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPD_RD = 2'd2,
    ST_UPD_WR = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] init_addr_q, init_addr_d;
  logic               rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0]  count_q, count_d;
  logic [INDEX_W-1:0] fifo_idx_q [FIFO_DEPTH];
  logic               fifo_tkn_q [FIFO_DEPTH];

  logic               full;
  logic               push;
  logic               pop;
  logic               rd_grant;
  logic [INDEX_W-1:0] head_idx;
  logic               head_tkn;
  logic [CNT_W-1:0]   sat_val;
  logic               mem_en_c;
  logic               mem_we_c;
  logic [INDEX_W-1:0] mem_addr_c;
  logic [CNT_W-1:0]   mem_wdata_c;

  assign full       = (count_q == CNTF_W'(FIFO_DEPTH));
  assign o_rd_ready = (state_q == ST_RUN) && !full;
  assign o_up_ready = (state_q != ST_INIT) && (count_q < CNTF_W'(FIFO_DEPTH));
  assign push       = i_up_valid && o_up_ready;
  assign pop        = (state_q == ST_UPD_WR);
  assign rd_grant   = i_rd_valid && o_rd_ready;
  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_tkn   = fifo_tkn_q[rd_ptr_q];

  // Saturating step of the counter returned by the UPD_RD read
  always_comb begin
    sat_val = i_mem_rdata;
    if (head_tkn) begin
      if (i_mem_rdata != CNT_W'(CNT_MAX)) sat_val = i_mem_rdata + CNT_W'(1);
    end else begin
      if (i_mem_rdata != '0) sat_val = i_mem_rdata - CNT_W'(1);
    end
  end

  // FIFO bookkeeping; pointers wrap naturally since depth is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTF_W'(1);
      2'b01:   count_d = count_q - CNTF_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next state and SRAM port control; RUN decisions use the post-push occupancy
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    rd_valid_d  = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    unique case (state_q)
      ST_INIT: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = init_addr_q;
        mem_wdata_c = CNT_W'(INIT_VAL);
        init_addr_d = init_addr_q + INDEX_W'(1);
        if (init_addr_q == INDEX_W'(LAST_ADDR)) begin
          init_addr_d = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_grant) begin
          mem_en_c   = 1'b1;
          mem_addr_c = i_rd_index;
          rd_valid_d = 1'b1;
        end
        if (count_d == CNTF_W'(FIFO_DEPTH)) begin
          state_d = ST_UPD_RD;
        end else if (!rd_grant && (count_d != '0)) begin
          state_d = ST_UPD_RD;
        end
      end
      ST_UPD_RD: begin
        mem_en_c   = 1'b1;
        mem_addr_c = head_idx;
        state_d    = ST_UPD_WR;
      end
      ST_UPD_WR: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = head_idx;
        mem_wdata_c = sat_val;
        state_d     = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // The SRAM is silenced while reset is held so a reset landing mid-RMW never writes
  assign o_mem_en    = mem_en_c && rst_n;
  assign o_mem_we    = mem_we_c && rst_n;
  assign o_mem_addr  = mem_addr_c;
  assign o_mem_wdata = mem_wdata_c;

  assign o_init_busy  = (state_q == ST_INIT);
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_counter = rd_valid_q ? i_mem_rdata : '0;
  assign o_rd_taken   = o_rd_counter[CNT_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rd_valid_q  <= rd_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= i_up_index;
      fifo_tkn_q[wr_ptr_q] <= i_up_taken;
    end
  end

`ifdef PHT_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] upd_cnt_q, upd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    upd_cnt_d   = upd_cnt_q;
    if (i_rd_valid && !o_rd_ready && (state_q != ST_INIT)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_q == ST_UPD_WR) upd_cnt_d = upd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      upd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  assign o_stat_stall_cnt = stall_cnt_q;
  assign o_stat_upd_cnt   = upd_cnt_q;
`else
  assign o_stat_stall_cnt = '0;
  assign o_stat_upd_cnt   = '0;
`endif

endmodule

// File: doc/pht_access_scheduler.md
# pht_access_scheduler

Sequences all accesses to a single-port, non-resettable pattern-history-table SRAM of 2-bit saturating counters used by the global branch predictor. It initialises every entry after reset, arbitrates each cycle between decode-stage prediction reads and execute-stage outcome updates, and buffers updates in a small FIFO. Each update is applied as a two-cycle read-modify-write.

## Interface
Parameters:
- INDEX_W, 9, PHT index width; table holds 2**INDEX_W entries
- CNT_W, 2, counter width
- FIFO_DEPTH, 4, update FIFO entries (power of two, >=2)
- INIT_VAL, 1, counter value written during init (weakly not taken)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_rd_valid  in  1  prediction read request
- i_rd_index  in  INDEX_W  read index (GHR xor PC bits)
- o_rd_ready  out  1  read accepted this cycle when high with i_rd_valid
- o_rd_valid  out  1  read data valid
- o_rd_taken  out  1  counter MSB of returned entry
- o_rd_counter  out  CNT_W  returned counter
- i_up_valid  in  1  update push
- i_up_index  in  INDEX_W  entry to update
- i_up_taken  in  1  resolved outcome
- o_up_ready  out  1  FIFO can accept a push
- o_mem_en  out  1  SRAM access enable
- o_mem_we  out  1  SRAM write enable
- o_mem_addr  out  INDEX_W  SRAM address
- o_mem_wdata  out  CNT_W  SRAM write data
- i_mem_rdata  in  CNT_W  SRAM read data, valid 1 cycle after a read
- o_init_busy  out  1  init walk in progress
- o_stat_stall_cnt, o_stat_upd_cnt  out  32 each  statistics (macro only)

## Operation
- FSM states: INIT, RUN, UPD_RD, UPD_WR.
- INIT:
  - Write INIT_VAL to addresses 0..2**INDEX_W-1, one per cycle (o_mem_en=o_mem_we=1).
  - Go to RUN after the last address.
  - o_rd_ready=0 and o_up_ready=0 throughout.
- RUN grant priority, one SRAM access per cycle:
  - (1) FIFO full: drain, go to UPD_RD.
  - (2) i_rd_valid: read.
  - (3) FIFO non-empty: drain, go to UPD_RD.
  - (4) Otherwise: idle, o_mem_en=0.
- o_rd_ready = (state==RUN) && !full. It is a function of registered state only and never of i_rd_valid.
- Read: SRAM read at i_rd_index. The following cycle drives o_rd_valid=1, o_rd_counter=i_mem_rdata, o_rd_taken=i_mem_rdata[CNT_W-1].
- UPD_RD: SRAM read at FIFO head index; go to UPD_WR.
- UPD_WR:
  - Write the saturated value to the head index, pop the FIFO, return to RUN.
  - Saturation: taken gives min(c+1, 2**CNT_W-1); not-taken gives max(c-1, 0).
- Reads issued in UPD_RD/UPD_WR are not accepted (o_rd_ready=0).
- o_up_ready = (state!=INIT) && (count<FIFO_DEPTH), from registered count.
- Push and pop in the same cycle leave count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Updates still queued in the FIFO are not visible to reads; reads return SRAM contents only.

## Timing
- Reset (rst_n low at a clock edge):
  - FIFO empties; all pending updates are dropped.
  - Init address returns to 0; state=INIT.
  - Outputs: o_rd_valid=0, o_rd_taken=0, o_rd_counter=0, o_up_ready=0, o_rd_ready=0, o_mem_en=0, o_mem_we=0, o_init_busy=1, stat counters=0.
- Reset asserted mid-operation (including mid-INIT or mid-RMW) restarts the init walk from address 0.
- Init takes exactly 2**INDEX_W cycles after rst_n deasserts. o_init_busy falls in the cycle the FSM enters RUN.
- Read latency: o_rd_valid is high exactly 1 cycle after acceptance, for one cycle.
- Update latency with no competing reads: push at cycle t, UPD_RD at t+1, write at t+2.
- An update occupies the SRAM port for 2 cycles.
- Back-to-back reads sustain 1 per cycle until the FIFO fills.

## Configuration
- PHT_STATS_EN defined:
  - o_stat_stall_cnt increments each cycle with i_rd_valid=1 && o_rd_ready=0 (state RUN, UPD_RD or UPD_WR).
  - o_stat_upd_cnt increments on each UPD_WR.
  - Both wrap at 2**32.
- PHT_STATS_EN undefined: both outputs are tied to 0 and no counter registers are instantiated.

## Test plan
- Init (INDEX_W=4): release reset → 16 consecutive writes of 1 to addresses 0..15. o_init_busy falls after cycle 16. Then reading each index returns 1 (o_rd_taken=0).
- Saturation: three taken updates to index 5 → writes 2, 3, 3. Then two not-taken → writes 2, 1. A read of index 5 returns 1.
- Priority: fill the FIFO (4 pushes) while i_rd_valid is held high → o_rd_ready drops. The next cycles are UPD_RD then UPD_WR, and o_stat_stall_cnt increments by 2 with the macro defined.
- Read preference: FIFO holds 1 entry, i_rd_valid=1 → read granted first (o_rd_valid the next cycle). The drain starts once i_rd_valid=0.
- Simultaneous push/pop: push at count=4 during UPD_WR is blocked (o_up_ready=0). A push at count=2 during UPD_WR leaves count=2.
- Reset mid-RMW: assert rst_n=0 during UPD_RD with 3 updates queued → no write issued. Init restarts at address 0, and the queued updates are never applied.
